// File: rtl/rolling_variance_if.sv
// Sample/statistics bundle for the rolling variance engine.
// The master drives samples, and the slave returns the window statistics.
interface rolling_variance_if #(
  parameter int DATA_W = 8
) ();
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [DATA_W-1:0] mean;
  logic [2*DATA_W-1:0] sec_mom;
  logic [2*DATA_W-1:0] variance;
  logic              full;

  modport master (
    output clear, in_valid, data_in,
    input  out_valid, mean, sec_mom, variance, full
  );

  modport slave (
    input  clear, in_valid, data_in,
    output out_valid, mean, sec_mom, variance, full
  );
endinterface

// File: rtl/rolling_variance.sv
// Rolling-window mean, mean of squares and variance of the last
// 2**WINDOW_LOG2 samples. The design uses an accept register and two pipeline stages.
module rolling_variance #(
  parameter int DATA_W      = 8,
  parameter int WINDOW_LOG2 = 2
) (
  input  logic               clk,
  input  logic               rst,
  rolling_variance_if.slave  rv
);
  localparam int WIN = 1 << WINDOW_LOG2;
  localparam int SW  = DATA_W + WINDOW_LOG2;
  localparam int PW  = 2 * DATA_W;
  localparam int QW  = PW + WINDOW_LOG2;
  localparam logic [WINDOW_LOG2:0] CNT_MAX =
    {1'b1, {WINDOW_LOG2{1'b0}}};

  logic [DATA_W-1:0] fifo_q [WIN];
  logic [DATA_W-1:0] fifo_d [WIN];
  logic [DATA_W-1:0] new_q, new_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic              acc_q, acc_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [QW-1:0]     sqs_q, sqs_d;
  logic [WINDOW_LOG2:0] cnt_q, cnt_d;
  logic              s1v_q, s1v_d;
  logic [DATA_W-1:0] mean_q, mean_d;
  logic [PW-1:0]     sm_q, sm_d;
  logic [PW-1:0]     var_q, var_d;
  logic              ov_q, ov_d;

  logic              take;
  logic [PW-1:0]     sq_new, sq_old, msq;

  assign take = rv.in_valid & ~rv.clear;

  always_comb begin
    fifo_d = fifo_q;
    new_d  = new_q;
    old_d  = old_q;
    acc_d  = take;
    sum_d  = sum_q;
    sqs_d  = sqs_q;
    cnt_d  = cnt_q;
    s1v_d  = 1'b0;
    mean_d = mean_q;
    sm_d   = sm_q;
    var_d  = var_q;
    ov_d   = s1v_q;
    sq_new = PW'(new_q) * PW'(new_q);
    sq_old = PW'(old_q) * PW'(old_q);
    msq    = '0;

    if (take) begin
      fifo_d[0] = rv.data_in;
      for (int i = 1; i < WIN; i++)
        fifo_d[i] = fifo_q[i-1];
      new_d = rv.data_in;
      old_d = fifo_q[WIN-1];
    end

    if (acc_q) begin
      sum_d = sum_q + SW'(new_q) - SW'(old_q);
      sqs_d = sqs_q + QW'(sq_new) - QW'(sq_old);
      if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;
      s1v_d = (cnt_d == CNT_MAX);
    end

    if (s1v_q) begin
      mean_d = sum_q[SW-1:WINDOW_LOG2];
      sm_d   = sqs_q[QW-1:WINDOW_LOG2];
      msq    = PW'(mean_d) * PW'(mean_d);
      var_d  = (sm_d >= msq) ? sm_d - msq : '0;
    end

    // A flush restarts the statistics, but the data outputs keep their last values.
    if (rv.clear) begin
      for (int i = 0; i < WIN; i++)
        fifo_d[i] = '0;
      sum_d  = '0;
      sqs_d  = '0;
      cnt_d  = '0;
      s1v_d  = 1'b0;
      ov_d   = 1'b0;
      mean_d = mean_q;
      sm_d   = sm_q;
      var_d  = var_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++)
        fifo_q[i] <= '0;
      new_q  <= '0;
      old_q  <= '0;
      acc_q  <= 1'b0;
      sum_q  <= '0;
      sqs_q  <= '0;
      cnt_q  <= '0;
      s1v_q  <= 1'b0;
      mean_q <= '0;
      sm_q   <= '0;
      var_q  <= '0;
      ov_q   <= 1'b0;
    end else begin
      fifo_q <= fifo_d;
      new_q  <= new_d;
      old_q  <= old_d;
      acc_q  <= acc_d;
      sum_q  <= sum_d;
      sqs_q  <= sqs_d;
      cnt_q  <= cnt_d;
      s1v_q  <= s1v_d;
      mean_q <= mean_d;
      sm_q   <= sm_d;
      var_q  <= var_d;
      ov_q   <= ov_d;
    end
  end

  assign rv.out_valid = ov_q;
  assign rv.mean      = mean_q;
  assign rv.sec_mom   = sm_q;
  assign rv.variance  = var_q;
  assign rv.full      = (cnt_q == CNT_MAX);
endmodule

// File: tb/tb_rolling_variance.sv
// Bench for rolling_variance: a window model checks every cycle,
// and literal expectations pin the model for the directed cases.
module tb_rolling_variance;
  localparam int WIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  rolling_variance_if #(.DATA_W(8)) bus ();

  rolling_variance #(.DATA_W(8), .WINDOW_LOG2(2)) dut (
    .clk (clk),
    .rst (rst),
    .rv  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int m;
    int s;
    int v;
  } exp_t;

  exp_t expq[$];
  int   win[WIN];
  int   nacc = 0;
  bit   exp_full = 1'b0;
  int   last_m = 0;
  int   last_s = 0;
  int   last_v = 0;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t stats(int due);
    exp_t e;
    int sum, sqs;
    sum = 0;
    sqs = 0;
    for (int i = 0; i < WIN; i++) begin
      sum += win[i];
      sqs += win[i] * win[i];
    end
    e.due = due;
    e.m   = sum / WIN;
    e.s   = sqs / WIN;
    e.v   = e.s - e.m * e.m;
    if (e.v < 0) e.v = 0;
    return e;
  endfunction

  // The window model works at the edge level: accept, flush or reset.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      foreach (win[i]) win[i] = 0;
      nacc = 0;
      exp_full = 1'b0;
      expq.delete();
      last_m = 0;
      last_s = 0;
      last_v = 0;
    end else if (bus.clear) begin
      foreach (win[i]) win[i] = 0;
      nacc = 0;
      exp_full = 1'b0;
      expq.delete();
    end else begin
      exp_full = (nacc >= WIN);
      if (bus.in_valid) begin
        for (int i = WIN - 1; i > 0; i--)
          win[i] = win[i-1];
        win[0] = int'(bus.data_in);
        nacc++;
        if (nacc >= WIN)
          expq.push_back(stats(cyc + 2));
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit ev;
      exp_t e;
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      chk("out_valid", int'(bus.out_valid), int'(ev));
      if (ev) begin
        e = expq.pop_front();
        last_m = e.m;
        last_s = e.s;
        last_v = e.v;
      end
      chk("mean", int'(bus.mean), last_m);
      chk("sec_mom", int'(bus.sec_mom), last_s);
      chk("variance", int'(bus.variance), last_v);
      chk("full", int'(bus.full), int'(exp_full));
    end
  end

  task automatic drive(bit v, int d, bit c);
    bus.in_valid = v;
    bus.data_in  = 8'(d);
    bus.clear    = c;
    @(posedge clk);
    #2;
  endtask

  // The pulse for the sample just accepted must appear on the third negedge.
  task automatic lit(string nm, int m, int s, int v);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    repeat (3) @(negedge clk);
    chk({nm, ".ov"}, int'(bus.out_valid), 1);
    chk({nm, ".mean"}, int'(bus.mean), m);
    chk({nm, ".sec_mom"}, int'(bus.sec_mom), s);
    chk({nm, ".var"}, int'(bus.variance), v);
  endtask

  int rdata;

  initial begin
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ov", int'(bus.out_valid), 0);
    chk("reset.mean", int'(bus.mean), 0);
    chk("reset.full", int'(bus.full), 0);

    drive(1, 2, 0);
    drive(1, 4, 0);
    drive(1, 6, 0);
    drive(1, 8, 0);
    lit("fill", 5, 30, 5);
    chk("fill.full", int'(bus.full), 1);

    drive(1, 10, 0);
    lit("slide", 7, 54, 5);

    repeat (4) drive(1, 255, 0);
    lit("max", 255, 65025, 0);
    drive(1, 0, 0);
    drive(1, 255, 0);
    drive(1, 0, 0);
    drive(1, 255, 0);
    lit("alt", 127, 32512, 16383);

    drive(0, 0, 1);
    drive(1, 1, 0);
    drive(0, 0, 0);
    drive(1, 3, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    drive(1, 5, 0);
    drive(1, 7, 0);
    lit("bubble", 4, 21, 5);

    drive(0, 0, 1);
    drive(1, 1, 0);
    drive(1, 2, 0);
    drive(1, 3, 0);
    drive(0, 0, 1);
    drive(1, 200, 1);
    repeat (4) drive(1, 9, 0);
    lit("clear", 9, 81, 0);

    drive(0, 0, 1);
    drive(1, 11, 0);
    drive(1, 12, 0);
    drive(1, 13, 0);
    drive(1, 14, 0);
    rst = 1'b1;
    drive(0, 0, 0);
    @(negedge clk);
    chk("rst.ov", int'(bus.out_valid), 0);
    chk("rst.mean", int'(bus.mean), 0);
    chk("rst.var", int'(bus.variance), 0);
    chk("rst.full", int'(bus.full), 0);
    drive(0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 0);
    @(negedge clk);
    chk("rst.ov2", int'(bus.out_valid), 0);

    for (int k = 0; k < 4000; k++) begin
      int r;
      r = int'($urandom_range(0, 999));
      case ($urandom % 4)
        0: rdata = 0;
        1: rdata = 255;
        default: rdata = int'($urandom % 256);
      endcase
      if (r < 5) begin
        rst = 1'b1;
        drive(0, 0, 0);
        rst = 1'b0;
      end else begin
        drive(($urandom % 10) < 7, rdata, r < 25);
      end
    end

    repeat (5) drive(0, 0, 0);
    chk("drain", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
